// File: rtl/alu_pkg.sv
// Shared defaults and source-index constants for the ALU result mux pipeline.
package alu_pkg;

    localparam int ALU_DATA_W  = 64;
    localparam int ALU_CMP_W   = 10;
    localparam int ALU_NUM_SRC = 4;
    localparam int ALU_TAG_W   = 8;

    localparam int SRC_CMP  = 0;
    localparam int SRC_PASS = 1;
    localparam int SRC_XOR  = 2;
    localparam int SRC_ADD  = 3;

    // Select width never drops below one bit, even for two sources.
    function automatic int sel_width(input int num_src);
        return ($clog2(num_src) > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/alu_src_select.sv
// Stateless source selector: comparator, full-width slices, or zero when out of range.
module alu_src_select
    import alu_pkg::*;
#(
    parameter  int DATA_W  = ALU_DATA_W,
    parameter  int CMP_W   = ALU_CMP_W,
    parameter  int NUM_SRC = ALU_NUM_SRC,
    localparam int SEL_W   = sel_width(NUM_SRC)
) (
    input  logic [CMP_W-1:0]              cmp_i,
    input  logic [(NUM_SRC-1)*DATA_W-1:0] src_i,
    input  logic [SEL_W-1:0]              select_i,
    output logic [DATA_W-1:0]             result_o,
    output logic                          sel_bad_o
);

    localparam logic [SEL_W:0] NUM_SRC_EXT = (SEL_W + 1)'(NUM_SRC);

    assign sel_bad_o = {1'b0, select_i} >= NUM_SRC_EXT;

    always_comb begin
        result_o = '0;
        if (select_i == SEL_W'(SRC_CMP)) begin
            result_o = DATA_W'(cmp_i);
        end
        for (int unsigned k = 1; k < NUM_SRC; k++) begin
            if (select_i == SEL_W'(k)) begin
                result_o = src_i[(k-1)*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/alu_result_mux_pipe.sv
// Registered result mux with a 2-entry skid buffer, sequence tags and a sticky bad-select flag.
module alu_result_mux_pipe
    import alu_pkg::*;
#(
    parameter  int DATA_W  = ALU_DATA_W,
    parameter  int CMP_W   = ALU_CMP_W,
    parameter  int NUM_SRC = ALU_NUM_SRC,
    parameter  int TAG_W   = ALU_TAG_W,
    localparam int SEL_W   = sel_width(NUM_SRC)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [CMP_W-1:0]              cmp_i,
    input  logic [(NUM_SRC-1)*DATA_W-1:0] src_i,
    input  logic [SEL_W-1:0]              select_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [DATA_W-1:0]             result_o,
    output logic [TAG_W-1:0]              tag_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          sel_err_o,
    input  logic                          clr_err_i
);

    logic              ready_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic              skid_valid_q;
    logic              skid_valid_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [TAG_W-1:0]  skid_tag_q;
    logic [TAG_W-1:0]  tag_cnt_q;
    logic              sel_err_q;

    logic              accept;
    logic              load_out;
    logic [DATA_W-1:0] sel_data;
    logic              sel_bad;

    alu_src_select #(
        .DATA_W  (DATA_W),
        .CMP_W   (CMP_W),
        .NUM_SRC (NUM_SRC)
    ) u_src_select (
        .cmp_i     (cmp_i),
        .src_i     (src_i),
        .select_i  (select_i),
        .result_o  (sel_data),
        .sel_bad_o (sel_bad)
    );

    assign accept   = valid_i && ready_q;
    // Output register can take a new entry when empty or being drained this edge.
    assign load_out = !out_valid_q || ready_i;

    // Skid only fills when the output register is stuck; it always empties on the next load.
    always_comb begin
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            skid_valid_d = !load_out;
        end else if (accept && !load_out) begin
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
            tag_cnt_q    <= '0;
            sel_err_q    <= 1'b0;
        end else begin
            if (load_out) begin
                if (skid_valid_q) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= skid_data_q;
                    out_tag_q   <= skid_tag_q;
                end else begin
                    out_valid_q <= accept;
                    if (accept) begin
                        out_data_q <= sel_data;
                        out_tag_q  <= tag_cnt_q;
                    end
                end
            end
            if (!skid_valid_q && accept && !load_out) begin
                skid_data_q <= sel_data;
                skid_tag_q  <= tag_cnt_q;
            end
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
            if (accept) begin
                tag_cnt_q <= tag_cnt_q + TAG_W'(1);
            end
            if (accept && sel_bad) begin
                sel_err_q <= 1'b1;
            end else if (clr_err_i) begin
                sel_err_q <= 1'b0;
            end
        end
    end

    assign ready_o   = ready_q;
    assign valid_o   = out_valid_q;
    assign result_o  = out_data_q;
    assign tag_o     = out_tag_q;
    assign sel_err_o = sel_err_q;

endmodule
